// File: rtl/out_port_serial_tx.sv
// ----------------------------------------------------------------------------
// out_port_serial_tx : FIFO-buffered 8N1 serialiser for one memory-mapped output port (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module out_port_serial_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] port_data,
  input  logic                 port_wr_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 fifo_full,
  output logic                 overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CLK_W-1:0] LAST_CLK = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [CLK_W-1:0]     bit_cnt, bit_cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic                 tx_n;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, count_n;
  logic                 push, pop, drop;
  logic                 fifo_empty;

  // Fullness is judged on the registered count, so a pop in the same cycle
  // does not rescue a write that arrives while full.
  assign fifo_empty = (count == '0);
  assign push       = port_wr_en && (count != DEPTH_C);
  assign drop       = port_wr_en && (count == DEPTH_C);

  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= port_data;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    pop       = 1'b0;

    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_n   = mem[rd_ptr];
          bit_cnt_n = '0;
          state_n   = START;
        end
      end

      START: begin
        if (bit_cnt == LAST_CLK) begin
          bit_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          bit_cnt_n = bit_cnt + CLK_W'(1);
        end
      end

      DATA: begin
        if (bit_cnt == LAST_CLK) begin
          bit_cnt_n = '0;
          if (bit_idx == LAST_IDX) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
          end
        end else begin
          bit_cnt_n = bit_cnt + CLK_W'(1);
        end
      end

      STOP: begin
        if (bit_cnt == LAST_CLK) begin
          bit_cnt_n = '0;
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt + CLK_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase

    // Line level is computed from the next state so the flop presents it
    // in the same cycle the FSM enters that state.
    tx_n = 1'b1;
    if (state_n == START) begin
      tx_n = 1'b0;
    end else if (state_n == DATA) begin
      tx_n = shift_n[bit_idx_n];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      busy      <= 1'b0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
      tx        <= tx_n;
      count     <= count_n;
      busy      <= (count_n != '0) || (state_n != IDLE);
      fifo_full <= (count_n == DEPTH_C);
      overflow  <= drop;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_out_port_serial_tx.sv
// ----------------------------------------------------------------------------
// tb_out_port_serial_tx : scoreboard bench decoding the serial line (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_out_port_serial_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_data = 8'h00;
  logic       port_wr_en = 1'b0;
  logic       tx, busy, fifo_full, overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frame_cnt = 0;
  int         ovf_cnt = 0;
  int         last_start = -1;
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;

  out_port_serial_tx #(
    .DATA_BITS(8),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .port_data(port_data),
    .port_wr_en(port_wr_en),
    .tx(tx),
    .busy(busy),
    .fifo_full(fifo_full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] b, input bit accepted);
    port_data  = b;
    port_wr_en = 1'b1;
    if (accepted) exp_q.push_back(b);
    tick();
    port_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy !== 1'b0 || mon_active || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  // Serial-line monitor: decodes frames at mid-bit and scores each byte.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_active = 1'b0;
      end else begin
        if (overflow === 1'b1) ovf_cnt++;
        if (!mon_active) begin
          if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            last_start = cyc;
            start_q.push_back(cyc);
          end
        end else begin
          mon_cnt++;
          if (mon_cnt == CPB / 2) check("start_bit", 32'(tx), 32'd0);
          if (mon_cnt >= CPB + CPB / 2 && mon_cnt < 9 * CPB && ((mon_cnt - CPB / 2) % CPB) == 0)
            mon_byte[(mon_cnt - CPB - CPB / 2) / CPB] = tx;
          if (mon_cnt == 9 * CPB + CPB / 2) begin
            logic [8:0] exp9;
            check("stop_bit", 32'(tx), 32'd1);
            exp9 = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
            check("frame_byte", 32'({1'b0, mon_byte}), 32'(exp9));
            frame_cnt++;
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int k;
    int f0;
    int o0;
    int bad_tx, bad_busy, bad_full, bad_ovf;

    // Reset state
    tick();
    tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Long quiet period
    bad_tx = 0; bad_busy = 0; bad_full = 0; bad_ovf = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (fifo_full !== 1'b0) bad_full++;
      if (overflow !== 1'b0) bad_ovf++;
    end
    check("quiet_tx", 32'(bad_tx), 32'd0);
    check("quiet_busy", 32'(bad_busy), 32'd0);
    check("quiet_full", 32'(bad_full), 32'd0);
    check("quiet_ovf", 32'(bad_ovf), 32'd0);

    // Single byte: latency and busy duration
    k = cyc;
    f0 = frame_cnt;
    write(8'hA5, 1'b1);
    check("s1_tx_before_start", 32'(tx), 32'd1);
    while (cyc < k + 2 + FRAME - 1) tick();
    check("s1_busy_last", 32'(busy), 32'd1);
    tick();
    check("s1_busy_drop", 32'(busy), 32'd0);
    check("s1_latency", 32'(last_start), 32'(k + 2));
    check("s1_frames", 32'(frame_cnt - f0), 32'd1);

    // Back-to-back frames
    repeat (3) tick();
    start_q.delete();
    write(8'h01, 1'b1);
    write(8'h80, 1'b1);
    wait_idle("s2_timeout", 200);
    check("s2_frames", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2) check("s2_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME));

    // FIFO fill and overflow
    repeat (3) tick();
    f0 = frame_cnt;
    o0 = ovf_cnt;
    for (int i = 0; i < 6; i++) begin
      write(8'h10 + 8'(i), i < 5);
      if (i == 4) check("s3_full", 32'(fifo_full), 32'd1);
      if (i == 5) check("s3_ovf_pulse", 32'(overflow), 32'd1);
    end
    tick();
    check("s3_ovf_single", 32'(overflow), 32'd0);
    wait_idle("s3_timeout", 400);
    check("s3_frames", 32'(frame_cnt - f0), 32'd5);
    check("s3_ovf_count", 32'(ovf_cnt - o0), 32'd1);
    check("s3_full_after", 32'(fifo_full), 32'd0);

    // Inputs toggle without strobe during a frame
    repeat (3) tick();
    f0 = frame_cnt;
    write(8'hC3, 1'b1);
    for (int i = 0; i < 30; i++) begin
      port_data = 8'($urandom);
      tick();
    end
    wait_idle("s6_timeout", 200);
    check("s6_frames", 32'(frame_cnt - f0), 32'd1);

    // Reset in the middle of a data bit with two bytes queued
    repeat (3) tick();
    k = cyc;
    write(8'h3C, 1'b1);
    write(8'h5A, 1'b1);
    write(8'h66, 1'b1);
    while (cyc < k + 7) tick();
    check("s4_mid_data_low", 32'(tx), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("s4_async_tx", 32'(tx), 32'd1);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("s4_busy", 32'(busy), 32'd0);
    check("s4_full", 32'(fifo_full), 32'd0);
    f0 = frame_cnt;
    repeat (200) tick();
    check("s4_no_frames", 32'(frame_cnt - f0), 32'd0);
    k = cyc;
    write(8'h96, 1'b1);
    wait_idle("s4_timeout", 200);
    check("s4_latency", 32'(last_start), 32'(k + 2));
    check("s4_frames", 32'(frame_cnt - f0), 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
